// File: rtl/pack_round_stage.sv
// Pack/round stage: rounds an unpacked {sign, exp, man+GRS} value into an IEEE-style word.
// Define PACK_ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates.
module pack_round_stage #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int GRS_W = 3,
  parameter int TAG_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_bypass,
  input  logic                     in_sign,
  input  logic [EXP_W+1:0]         in_exp,
  input  logic [MAN_W+GRS_W:0]     in_man,
  input  logic [EXP_W+MAN_W:0]     in_raw,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_ovf,
  output logic [15:0]              ovf_count
);

  // Handshake: a transfer happens on a rising edge where in_valid && in_ready.
  // out_valid holds until out_ready is seen; the output register refills in the
  // same cycle it drains, so in_ready = !out_valid || out_ready.

  localparam int XW = EXP_W + 3;
  localparam logic signed [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EMIN = XW'(2 - (1 << (EXP_W - 1)));
  localparam logic signed [XW-1:0] ONE  = XW'(1);

`ifdef PACK_ROUND_NEAREST_EN
  localparam bit NEAREST = 1'b1;
`else
  localparam bit NEAREST = 1'b0;
`endif

  logic                    hidden;
  logic [MAN_W-1:0]        frac;
  logic                    guard;
  logic                    sticky_lo;
  logic                    round_inc;
  logic [MAN_W+1:0]        sig_sum;
  logic signed [XW-1:0]    exp_x;
  logic signed [XW-1:0]    exp_r;
  logic                    hid_r;
  logic [MAN_W-1:0]        frac_r;
  logic [EXP_W-1:0]        exp_field;
  logic [EXP_W+MAN_W:0]    result_next;
  logic                    ovf_next;
  logic                    xfer;

  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    hidden    = in_man[MAN_W+GRS_W];
    frac      = in_man[GRS_W +: MAN_W];
    guard     = in_man[GRS_W-1];
    sticky_lo = |in_man[GRS_W-2:0];
    round_inc = NEAREST && guard && (sticky_lo || frac[0]);
    sig_sum   = {1'b0, hidden, frac} + (MAN_W+2)'(round_inc);
    exp_x     = {in_exp[EXP_W+1], in_exp};
    // Carry past the hidden bit renormalises; carry into a zero hidden bit turns
    // a subnormal into the smallest normal, which is the biased-exponent increment.
    if (sig_sum[MAN_W+1]) begin
      exp_r  = exp_x + ONE;
      hid_r  = 1'b1;
      frac_r = '0;
    end else begin
      exp_r  = exp_x;
      hid_r  = sig_sum[MAN_W];
      frac_r = sig_sum[MAN_W-1:0];
    end
    exp_field   = exp_r[EXP_W-1:0] + BIAS[EXP_W-1:0];
    ovf_next    = 1'b0;
    result_next = {in_sign, exp_field, frac_r};
    if (in_bypass) begin
      result_next = in_raw;
    end else if (exp_r > BIAS) begin
      ovf_next    = 1'b1;
      result_next = {in_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (exp_r < EMIN) begin
      result_next = {in_sign, {(EXP_W+MAN_W){1'b0}}};
    end else if (exp_r == EMIN && !hid_r) begin
      result_next = {in_sign, {EXP_W{1'b0}}, frac_r};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_ovf    <= 1'b0;
      ovf_count  <= '0;
    end else if (xfer) begin
      out_valid  <= 1'b1;
      out_result <= result_next;
      out_tag    <= in_tag;
      out_ovf    <= ovf_next;
      if (ovf_next && ovf_count != 16'hFFFF)
        ovf_count <= ovf_count + 16'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pack_round_stage.sv
// Directed scoreboard bench for pack_round_stage (default parameters, either rounding build).
module tb_pack_round_stage;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_bypass;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [26:0] in_man;
  logic [31:0] in_raw;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [7:0]  out_tag;
  logic        out_ovf;
  logic [15:0] ovf_count;

  logic [40:0] exp_q[$];
  int          checks;
  int          failures;
  int          ovf_model;

  pack_round_stage dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_bypass(in_bypass),
    .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man), .in_raw(in_raw),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_ovf(out_ovf),
    .ovf_count(ovf_count)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [26:0] mk_man(input logic h, input logic [22:0] f, input logic [2:0] g);
    return {h, f, g};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // driver: present one word and hold it until accepted; expectation pushed on acceptance
  task automatic send(input logic byp, input logic sgn, input int e, input logic [26:0] man,
                      input logic [31:0] raw, input logic [7:0] tag,
                      input logic [31:0] want, input logic want_ovf);
    logic [31:0] ev;
    bit got;
    ev = e;
    in_bypass = byp; in_sign = sgn; in_exp = ev[9:0]; in_man = man;
    in_raw = raw; in_tag = tag; in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (in_ready) begin got = 1; break; end
    end
    if (got) begin
      exp_q.push_back({want, tag, want_ovf});
      if (want_ovf) ovf_model++;
      @(posedge clock); #1;
    end else begin
      checks++; failures++;
      $display("FAIL send_timeout tag=%h in_ready=%b want=1", tag, in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0) begin done = 1; break; end
    end
    @(posedge clock); #1;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d want=0", exp_q.size());
    end
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    logic [40:0] e;
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output got=%h/%h/%b want=none", out_result, out_tag, out_ovf);
      end else begin
        e = exp_q.pop_front();
        if ({out_result, out_tag, out_ovf} !== e) begin
          failures++;
          $display("FAIL result tag=%h got=%h ovf=%b want=%h ovf=%b",
                   e[8:1], out_result, out_ovf, e[40:9], e[0]);
        end
      end
    end
  end

  initial begin
    logic [31:0] w_carry, w_tie, w_odd, w_max_rnd;
    logic        o_max_rnd;
    checks = 0; failures = 0; ovf_model = 0;
    reset = 1'b1; in_valid = 1'b0; in_bypass = 1'b0; in_sign = 1'b0;
    in_exp = '0; in_man = '0; in_raw = '0; in_tag = '0; out_ready = 1'b1;
`ifdef PACK_ROUND_NEAREST_EN
    w_carry = 32'h40000000; w_tie = 32'h3F800000; w_odd = 32'h3F800002;
    w_max_rnd = 32'h7F800000; o_max_rnd = 1'b1;
`else
    w_carry = 32'h3FFFFFFF; w_tie = 32'h3F800000; w_odd = 32'h3F800001;
    w_max_rnd = 32'h7F7FFFFF; o_max_rnd = 1'b0;
`endif

    // reset state, with a transfer offered during the last reset cycle
    repeat (2) @(posedge clock);
    #1 in_valid = 1'b1; in_man = mk_man(1'b1, 23'h0, 3'b000); in_tag = 8'hEE;
    @(negedge clock);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
    check("rst_ovf_count", {16'b0, ovf_count}, 32'h0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_out_tag", {24'b0, out_tag}, 32'h0);
    check("rst_out_ovf", {31'b0, out_ovf}, 32'h0);
    @(posedge clock); #1 reset = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    check("rst_drop_xfer", {31'b0, out_valid}, 32'h0);
    @(posedge clock); #1;

    // one-cycle latency for 1.0
    send(0, 0, 0, mk_man(1'b1, 23'h0, 3'b000), 32'h0, 8'h01, 32'h3F800000, 1'b0);
    check("latency_valid", {31'b0, out_valid}, 32'h1);
    send(0, 0, 128, mk_man(1'b1, 23'h0, 3'b000), 32'h0, 8'h02, 32'h7F800000, 1'b1);
    @(negedge clock);
    check("ovf_count_first", {16'b0, ovf_count}, 32'h1);
    @(posedge clock); #1;
    send(0, 0, -127, mk_man(1'b1, 23'h0, 3'b000), 32'h0, 8'h03, 32'h00000000, 1'b0);
    send(0, 1, -127, mk_man(1'b1, 23'h0, 3'b000), 32'h0, 8'h04, 32'h80000000, 1'b0);
    send(0, 0, 0, mk_man(1'b1, 23'h7FFFFF, 3'b100), 32'h0, 8'h05, w_carry, 1'b0);
    send(0, 0, 0, mk_man(1'b1, 23'h0, 3'b100), 32'h0, 8'h06, w_tie, 1'b0);
    send(0, 0, 0, mk_man(1'b1, 23'h1, 3'b110), 32'h0, 8'h07, w_odd, 1'b0);
    send(0, 0, 0, mk_man(1'b1, 23'h0, 3'b011), 32'h0, 8'h08, 32'h3F800000, 1'b0);
    send(0, 0, 127, mk_man(1'b1, 23'h7FFFFF, 3'b000), 32'h0, 8'h09, 32'h7F7FFFFF, 1'b0);
    send(0, 0, 127, mk_man(1'b1, 23'h7FFFFF, 3'b100), 32'h0, 8'h0A, w_max_rnd, o_max_rnd);
    send(0, 0, -126, mk_man(1'b0, 23'h400000, 3'b000), 32'h0, 8'h0B, 32'h00400000, 1'b0);
    send(0, 1, 1, mk_man(1'b1, 23'h400000, 3'b000), 32'h0, 8'h0C, 32'hC0400000, 1'b0);
    send(0, 1, 200, mk_man(1'b1, 23'h123456, 3'b111), 32'h0, 8'h0D, 32'hFF800000, 1'b1);
    send(1, 0, 128, mk_man(1'b1, 23'h0, 3'b111), 32'hC0490FDB, 8'h0E, 32'hC0490FDB, 1'b0);
    drain();
    @(negedge clock);
    check("ovf_count_model", {16'b0, ovf_count}, ovf_model);
    @(posedge clock); #1;

    // backpressure: hold B while A sits stalled
    out_ready = 1'b0;
    send(0, 0, 0, mk_man(1'b1, 23'h0, 3'b000), 32'h0, 8'h20, 32'h3F800000, 1'b0);
    in_bypass = 1'b0; in_sign = 1'b1; in_exp = 10'd1; in_man = mk_man(1'b1, 23'h0, 3'b000);
    in_tag = 8'h21; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("stall_in_ready", {31'b0, in_ready}, 32'h0);
      check("stall_result", out_result, 32'h3F800000);
      check("stall_tag", {24'b0, out_tag}, 32'h20);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    send(0, 1, 1, mk_man(1'b1, 23'h0, 3'b000), 32'h0, 8'h21, 32'hC0000000, 1'b0);
    drain();

    // reset while a result is stalled
    out_ready = 1'b0;
    send(0, 0, 128, mk_man(1'b1, 23'h0, 3'b000), 32'h0, 8'h30, 32'h7F800000, 1'b1);
    @(negedge clock);
    check("pre_rst_ovf_count", {16'b0, ovf_count}, ovf_model);
    @(posedge clock); #1 reset = 1'b1;
    exp_q.delete(); ovf_model = 0;
    @(posedge clock);
    @(negedge clock);
    check("stall_rst_valid", {31'b0, out_valid}, 32'h0);
    check("stall_rst_ovf_count", {16'b0, ovf_count}, 32'h0);
    @(posedge clock); #1 reset = 1'b0; out_ready = 1'b1;
    send(0, 0, 0, mk_man(1'b1, 23'h0, 3'b000), 32'h0, 8'h31, 32'h3F800000, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pack_round_stage.md
PACK_ROUND_STAGE -- requirements
Module: pack_round_stage

Interface
REQ-001 SHALL have parameter EXP_W, default 8, meaning packed exponent width.
REQ-002 SHALL have parameter MAN_W, default 23, meaning packed fraction width, excluding the hidden bit.
REQ-003 SHALL have parameter GRS_W, default 3, meaning the number of guard/round/sticky bits below the fraction LSB, at least 2.
REQ-004 SHALL have parameter TAG_W, default 8, meaning instruction tag width.
REQ-005 SHALL have port clock, input, 1 bit, rising-edge clock.
REQ-006 SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1 bit, upstream data valid.
REQ-008 SHALL have port in_ready, output, 1 bit, stage can accept data.
REQ-009 SHALL have port in_bypass, input, 1 bit; when high, in_raw passes through unpacked.
REQ-010 SHALL have port in_sign, input, 1 bit, result sign.
REQ-011 SHALL have port in_exp, input, EXP_W+2 bits, signed unbiased exponent.
REQ-012 SHALL have port in_man, input, MAN_W+1+GRS_W bits; MSB is the hidden bit, the low GRS_W bits are guard/round/sticky.
REQ-013 SHALL have port in_raw, input, 1+EXP_W+MAN_W bits, bypass word.
REQ-014 SHALL have port in_tag, input, TAG_W bits, instruction tag.
REQ-015 SHALL have port out_valid, output, 1 bit, result valid.
REQ-016 SHALL have port out_ready, input, 1 bit, downstream accepts.
REQ-017 SHALL have port out_result, output, 1+EXP_W+MAN_W bits, packed IEEE-style word {sign, exponent, fraction}.
REQ-018 SHALL have port out_tag, output, TAG_W bits, tag aligned with out_result.
REQ-019 SHALL have port out_ovf, output, 1 bit, high when the current result saturated to infinity.
REQ-020 SHALL have port ovf_count, output, 16 bits, saturating overflow counter.

Function
REQ-021 SHALL drive in_ready = !out_valid || out_ready; a transfer occurs when in_valid && in_ready.
REQ-022 SHALL register the result one cycle after the transfer; out_valid is set on transfer, and cleared when out_ready is high with no new transfer.
REQ-023 SHALL hold out_result/out_tag/out_ovf stable while out_valid && !out_ready.
REQ-024 SHALL use BIAS = 2^(EXP_W-1)-1 and EMIN = 1-BIAS.
REQ-025 SHALL round the fraction to MAN_W bits, with carry-out from the fraction incrementing the exponent and clearing the fraction; the rounding mode is defined by REQ-036/REQ-037.
REQ-026 SHALL, if the post-round exponent > BIAS, output {sign, all-ones exponent, zero fraction} and set out_ovf.
REQ-027 SHALL, if exponent == EMIN and hidden bit == 0, output biased exponent 0 with the fraction kept (subnormal).
REQ-028 SHALL, if exponent < EMIN, output signed zero.
REQ-029 SHALL otherwise output {sign, exp+BIAS, rounded fraction}.
REQ-030 SHALL, with in_bypass high, output in_raw unchanged, with out_ovf=0 and no rounding.
REQ-031 SHALL increment ovf_count on each accepted transfer producing out_ovf=1, saturating at 16'hFFFF.

Reset
REQ-032 SHALL, while reset is high, set out_valid=0, out_ovf=0, ovf_count=0, out_result=0 and out_tag=0; in_ready is then 1.
REQ-033 SHALL make reset override a simultaneous transfer, so the data is dropped; the first transfer is accepted in the cycle after reset deasserts.
REQ-034 SHALL discard a result stalled by out_ready=0 when reset is asserted.

Configuration
REQ-035 SHALL use macro PACK_ROUND_NEAREST_EN to select the rounding mode.
REQ-036 SHALL, when PACK_ROUND_NEAREST_EN is defined, use round-to-nearest-even: increment when guard=1 and (any lower GRS bit=1 or fraction LSB=1).
REQ-037 SHALL, when PACK_ROUND_NEAREST_EN is undefined, truncate: GRS bits are ignored and there is no carry.

Verification
REQ-038 SHALL cover: sign=0, exp=0, man hidden=1, fraction=0, GRS=000 -> out_result 32'h3F800000, out_ovf=0, after 1 cycle.
REQ-039 SHALL cover: exp=128 -> 32'h7F800000, out_ovf=1, ovf_count increments 0->1; exp=-127 -> 32'h00000000.
REQ-040 SHALL cover, with nearest enabled: exp=0, fraction=all ones, GRS=100 -> 32'h40000000 (carry); fraction=0, GRS=100 -> 32'h3F800000 (tie to even); with truncation both -> 32'h3FFFFFFF / 32'h3F800000.
REQ-041 SHALL cover: out_ready=0 for 3 cycles with in_valid held -> in_ready=0, out_result stable; release -> next tag delivered, no loss or duplication.
REQ-042 SHALL cover: in_bypass=1, in_raw=32'hC0490FDB -> out_result 32'hC0490FDB, out_ovf=0.
REQ-043 SHALL cover: reset asserted while a result is stalled -> out_valid=0 and ovf_count=0 on the next cycle.
